// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, the TX state encoding and a level-saturation helper.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CLKDIV = 2'd2;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_FULL    = 1;
    localparam int STATUS_EMPTY   = 2;
    localparam int STATUS_OVF     = 3;
    localparam int STATUS_LVL_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // The STATUS level field is only 4 bits wide, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_level(input logic [31:0] lvl);
        if (lvl > 32'd15) begin
            return 4'hF;
        end else begin
            return lvl[3:0];
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic [Width-1:0]           wdata,
    output logic [Width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     level
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_r [Depth];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Bus-attached 8N1 UART transmitter: register decode, TX FIFO and bit FSM.
// Bus handshake mirrors the SRAM: gnt equals req, response one cycle later.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [15:0] ClkDivReset = 16'd434,
    parameter int          FifoDepth   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        tx_o,
    output logic        irq_tx_empty_o
);

    localparam int LvlW = $clog2(FifoDepth) + 1;

    logic            wr_txdata_s;
    logic            wr_status_s;
    logic            wr_clkdiv_s;
    logic            push_s;
    logic            pop_s;
    logic            ovf_clr_s;
    logic [7:0]      fifo_rdata_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [LvlW-1:0] fifo_level_s;
    logic [15:0]     clkdiv_merge_s;
    logic [15:0]     clkdiv_next_s;
    logic [31:0]     status_s;
    logic [31:0]     rdata_s;
    logic            unused_s;

    logic [15:0]     clkdiv_r;
    logic            ovf_r;
    tx_state_e       state_r;
    logic [15:0]     div_r;
    logic [15:0]     cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            irq_r;
    logic            rvalid_r;
    logic [31:0]     rdata_r;
    logic            err_r;

    assign gnt_o          = req_i;
    assign rvalid_o       = rvalid_r;
    assign rdata_o        = rdata_r;
    assign err_o          = err_r;
    assign tx_o           = tx_r;
    assign irq_tx_empty_o = irq_r;
    assign unused_s       = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

    // Write decode and the new CLKDIV value after byte-enable merging.
    always_comb begin
        wr_txdata_s    = req_i && we_i && (addr_i[3:2] == UART_TXDATA);
        wr_status_s    = req_i && we_i && (addr_i[3:2] == UART_STATUS);
        wr_clkdiv_s    = req_i && we_i && (addr_i[3:2] == UART_CLKDIV);
        push_s         = wr_txdata_s && be_i[0];
        ovf_clr_s      = wr_status_s && be_i[0] && wdata_i[STATUS_OVF];
        pop_s          = (state_r == TX_IDLE) && !fifo_empty_s;
        clkdiv_merge_s = {be_i[1] ? wdata_i[15:8] : clkdiv_r[15:8],
                          be_i[0] ? wdata_i[7:0]  : clkdiv_r[7:0]};
        if (clkdiv_merge_s == 16'd0) begin
            clkdiv_next_s = 16'd1;
        end else begin
            clkdiv_next_s = clkdiv_merge_s;
        end
    end

    // Read mux; writes and the reserved slot return zero.
    always_comb begin
        status_s                                  = 32'd0;
        status_s[STATUS_BUSY]                     = (state_r != TX_IDLE);
        status_s[STATUS_FULL]                     = fifo_full_s;
        status_s[STATUS_EMPTY]                    = fifo_empty_s;
        status_s[STATUS_OVF]                      = ovf_r;
        status_s[STATUS_LVL_LSB+3:STATUS_LVL_LSB] = sat_level(32'(fifo_level_s));
        rdata_s                                   = 32'd0;
        if (!we_i) begin
            case (addr_i[3:2])
                UART_STATUS: rdata_s = status_s;
                UART_CLKDIV: rdata_s = {16'd0, clkdiv_r};
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    uart_tx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .pop    (pop_s),
        .wdata  (wdata_i[7:0]),
        .rdata  (fifo_rdata_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .level  (fifo_level_s)
    );

    // Bus response and control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
            clkdiv_r <= ClkDivReset;
            ovf_r    <= 1'b0;
            irq_r    <= 1'b1;
        end else begin
            rvalid_r <= req_i;
            rdata_r  <= req_i ? rdata_s : 32'd0;
            err_r    <= req_i && (addr_i[3:2] == 2'd3);
            irq_r    <= (state_r == TX_IDLE) && fifo_empty_s;
            if (wr_clkdiv_s) begin
                clkdiv_r <= clkdiv_next_s;
            end
            // A push that is dropped wins over a clear in the same cycle (cannot coincide on one bus).
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Serialiser: each bit is held for div_r cycles, counter reloads on bit entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= TX_IDLE;
            div_r     <= ClkDivReset;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    if (!fifo_empty_s) begin
                        shift_r <= fifo_rdata_s;
                        div_r   <= clkdiv_r;
                        cnt_r   <= clkdiv_r - 16'd1;
                        tx_r    <= 1'b0;
                        state_r <= TX_START;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                TX_START: begin
                    if (cnt_r == 16'd0) begin
                        cnt_r     <= div_r - 16'd1;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= TX_DATA;
                    end else begin
                        cnt_r     <= cnt_r - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt_r == 16'd0) begin
                        cnt_r <= div_r - 16'd1;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= TX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= TX_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= TX_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: a register-access vector table followed
// by hand-written frame, overflow and mid-frame reset sequences.
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic [31:0] rd_v;
    logic        err_v;
    logic        rv_v;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    uart_tx_periph dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .we_i           (we),
        .be_i           (be),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .err_o          (err),
        .tx_o           (tx),
        .irq_tx_empty_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transaction; returns with the response sampled 1ns after the accepting edge.
    task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        rv_v = rvalid; rd_v = rdata; err_v = err;
    endtask

    initial begin
        logic [9:0] frame_bits;
        int cyc;
        int lows;

        vecs[0]  = '{1'b0, 4'hF, 32'h4, 32'h0,         32'h04,   1'b0};
        vecs[1]  = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h1B2,  1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'h0, 32'h0,         32'h0,    1'b0};
        vecs[3]  = '{1'b0, 4'hF, 32'hC, 32'h0,         32'h0,    1'b1};
        vecs[4]  = '{1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF, 32'h0,    1'b1};
        vecs[5]  = '{1'b1, 4'hF, 32'h8, 32'h0,         32'h0,    1'b0};
        vecs[6]  = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h1,    1'b0};
        vecs[7]  = '{1'b1, 4'h3, 32'h8, 32'h0000_1234, 32'h0,    1'b0};
        vecs[8]  = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h1234, 1'b0};
        vecs[9]  = '{1'b1, 4'h2, 32'h8, 32'hAB00_5600, 32'h0,    1'b0};
        vecs[10] = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h5634, 1'b0};
        vecs[11] = '{1'b1, 4'h1, 32'h8, 32'h0,         32'h0,    1'b0};
        vecs[12] = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h5600, 1'b0};
        vecs[13] = '{1'b1, 4'hF, 32'h8, 32'h4,         32'h0,    1'b0};
        vecs[14] = '{1'b0, 4'hF, 32'h8, 32'h0,         32'h4,    1'b0};
        vecs[15] = '{1'b0, 4'hF, 32'h4, 32'h0,         32'h04,   1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd1);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);

        @(negedge clk);
        req = 1'b1;
        #1;
        check("gnt_follows_req", 32'(gnt), 32'd1);
        req = 1'b0;
        #1;
        check("gnt_idle", 32'(gnt), 32'd0);

        // Register access vectors
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rvalid", i), 32'(rv_v), 32'd1);
            check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err_v), 32'(vecs[i].exp_err));
        end
        @(posedge clk);
        #1;
        check("rvalid_drops", 32'(rvalid), 32'd0);

        // Frame of 0x55 at CLKDIV=4: start, d0..d7 LSB first, stop, 4 cycles each
        frame_bits = {1'b1, 8'h55, 1'b0};
        bus(1'b1, 4'h1, 32'h0, 32'h55);
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) begin
                bus(1'b0, 4'hF, 32'h4, 32'h0);
                check("midframe_status", rd_v, 32'h05);
                check("midframe_irq", 32'(irq), 32'd0);
            end else if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("frame55_k%0d", k), 32'(tx), 32'(frame_bits[k/4]));
        end
        @(posedge clk);
        #1;
        check("frame55_idle_tx", 32'(tx), 32'd1);
        check("frame55_irq_late", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check("frame55_irq_back", 32'(irq), 32'd1);

        // Overflow: CLKDIV=2, 10 back-to-back pushes
        bus(1'b1, 4'hF, 32'h8, 32'h2);
        for (int i = 0; i < 10; i++) begin
            bus(1'b1, 4'h1, 32'h0, 32'(8'h10 + i));
        end
        bus(1'b0, 4'hF, 32'h4, 32'h0);
        check("ovf_status", rd_v, 32'h8B);
        bus(1'b1, 4'h1, 32'h4, 32'h08);
        bus(1'b0, 4'hF, 32'h4, 32'h0);
        check("ovf_cleared", rd_v, 32'h83);
        bus(1'b1, 4'hE, 32'h0, 32'hAA);
        check("be1110_rvalid", 32'(rv_v), 32'd1);
        check("be1110_err", 32'(err_v), 32'd0);
        bus(1'b0, 4'hF, 32'h4, 32'h0);
        check("be1110_no_push", rd_v, 32'h83);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_cycles", 32'(cyc), 32'd176);
        bus(1'b0, 4'hF, 32'h4, 32'h0);
        check("drained_status", rd_v, 32'h04);

        // Reset mid-frame at CLKDIV=8
        bus(1'b1, 4'hF, 32'h8, 32'h8);
        bus(1'b1, 4'h1, 32'h0, 32'hA5);
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_tx", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_irq", 32'(irq), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, 4'hF, 32'h4, 32'h0);
        check("post_reset_status", rd_v, 32'h04);
        bus(1'b0, 4'hF, 32'h8, 32'h0);
        check("post_reset_clkdiv", rd_v, 32'h1B2);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("no_residual_bits", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
